// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the instruction (I) and
// data (D) requesters. One outstanding transaction at a time, with a split
// addr_ok/data_ok handshake. A watchdog raises a sticky err when memory hangs.
// Optional feature macro: ARB_RR_EN. When it is defined, simultaneous requests
// are resolved round-robin. When it is undefined, fixed priority per D_PRIO is used.
module mem_bus_arbiter #(
  parameter int D_PRIO  = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ADDR = 2'd1,
    S_WAIT_DATA = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner;            // 1 = D owns (or last owned) the bus
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_size;
  logic [3:0]  r_strobe;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_req, w_pick_d, w_start, w_in_wait;
  logic        w_mv, w_addr_hs, w_data_hs;
  logic [15:0] w_cnt_inc;

  assign w_req     = i_valid | d_valid;
  assign w_start   = (r_state == S_IDLE) & w_req;
  assign w_in_wait = (r_state == S_WAIT_ADDR) | (r_state == S_WAIT_DATA);
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef ARB_RR_EN
  // On a tie, the side that did not own the previous transaction wins.
  assign w_pick_d = d_valid & (~i_valid | ~r_owner);
`else
  // On a tie, the static D_PRIO setting decides. The loser can starve.
  assign w_pick_d = d_valid & (~i_valid | (D_PRIO != 0));
`endif

  // Next-state logic and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_mv        = 1'b0;
    w_addr_hs   = 1'b0;
    w_data_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_state_nxt = S_WAIT_ADDR;
      end
      S_WAIT_ADDR: begin
        w_mv = 1'b1;
        if (m_addr_ok) begin
          w_addr_hs = 1'b1;
          if (m_data_ok) begin
            w_data_hs   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (m_data_ok) begin
          w_data_hs   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latch the winner's request fields when leaving IDLE. Later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
      r_wdata  <= '0;
    end else if (w_start) begin
      r_owner  <= w_pick_d;
      r_addr   <= w_pick_d ? d_addr   : i_addr;
      r_size   <= w_pick_d ? d_size   : 3'b010;
      r_strobe <= w_pick_d ? d_strobe : 4'h0;
      r_wdata  <= w_pick_d ? d_wdata  : 32'h0;
    end
  end

  // Watchdog: counts WAIT cycles per transaction and saturates. err is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_in_wait) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == TO_CNT) r_err <= 1'b1;
    end
  end

  // Outputs are forced to zero while reset is high, so an abandoned transaction produces no pulses.
  assign m_valid   = w_mv & ~reset;
  assign m_addr    = m_valid ? r_addr   : 32'h0;
  assign m_size    = m_valid ? r_size   : 3'b000;
  assign m_strobe  = m_valid ? r_strobe : 4'h0;
  assign m_wdata   = m_valid ? r_wdata  : 32'h0;

  assign i_addr_ok = w_addr_hs & ~r_owner & ~reset;
  assign d_addr_ok = w_addr_hs &  r_owner & ~reset;
  assign i_data_ok = w_data_hs & ~r_owner & ~reset;
  assign d_data_ok = w_data_hs &  r_owner & ~reset;
  assign i_rdata   = i_data_ok ? m_rdata : 32'h0;
  assign d_rdata   = d_data_ok ? m_rdata : 32'h0;
  assign err       = r_err & ~reset;

endmodule
